// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter and APB master that shares one APB slave between two requesters
// Optional feature macro: APB_TIMEOUT_EN ends an ACCESS phase with an error after TIMEOUT_CYCLES cycles.
// Ports:
//   PCLK, PRESETn          clock and asynchronous active-low reset
//   req_valid/req_write    per-requester pending flag and direction (bit i = requester i)
//   req_addr/req_wdata     per-requester address and write-data lanes
//   req_ready              one-hot combinational accept strobe, only while idle
//   rsp_valid/rsp_err      one-hot one-cycle completion pulse and its error flag
//   rsp_rdata              read data of the last completion, 0 after writes and timeouts
//   PSELx..PSLVERR         APB master-side pins
module apb_req_arbiter #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    PSELx,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [1:0]              rsp_valid_q, rsp_valid_d;
    logic                    rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    gnt;
    logic                    done;

    // On a tie the requester that was not served last wins.
    assign gnt = (&req_valid) ? ~last_q : req_valid[1];

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    // A timeout is a completion without PREADY; it reports an error and no data.
    assign done = PREADY || cnt_q == CNT_LAST;
`else
    assign done = PREADY;
`endif

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 2'b00;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        req_ready   = 2'b00;
`ifdef APB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: if (|req_valid) begin
                req_ready = gnt ? 2'b10 : 2'b01;
                pwrite_d  = req_write[gnt];
                paddr_d   = gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                pwdata_d  = gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                psel_d    = 1'b1;
                penable_d = 1'b0;
                last_d    = gnt;
                state_d   = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: if (done) begin
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = last_q ? 2'b10 : 2'b01;
                rsp_err_d   = !PREADY || PSLVERR;
                rsp_rdata_d = (pwrite_q || !PREADY) ? '0 : PRDATA;
                state_d     = IDLE;
            end else begin
`ifdef APB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 2'b00;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign PSELx     = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed vector bench for apb_req_arbiter
module tb_apb_req_arbiter;
    localparam int AW = 4;
    localparam int DW = 128;
    localparam logic [DW-1:0] A5 = {16{8'hA5}};
    localparam logic [DW-1:0] P  = {4{32'h1234_5678}};
    localparam logic [DW-1:0] W  = {4{32'hDEAD_BEEF}};
    localparam logic [DW-1:0] Z  = '0;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [1:0]      req_valid = '0, req_write = '0;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata, PWDATA;
    logic            rsp_err, PSELx, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PRDATA = '0;
    logic            PREADY = 1'b0, PSLVERR = 1'b0;

    apb_req_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [1:0]    rv, wr;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          rdy, err;
        logic [DW-1:0] rdat;
        logic [1:0]    rr;
        logic          sel, en, pw;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic [1:0]    vo;
        logic          eo;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t v[35];
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " PSELx"}, DW'(PSELx), Z);
        chk({tag, " PENABLE"}, DW'(PENABLE), Z);
        chk({tag, " rsp_valid"}, DW'(rsp_valid), Z);
        chk({tag, " rsp_rdata"}, rsp_rdata, Z);
        chk({tag, " PADDR"}, DW'(PADDR), Z);
    endtask

    initial begin #100000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    initial begin
        int n;
        //          rv     wr     a0    a1    d0  d1 rdy   err   rdat   rr     sel   en    pw    pa    pd  vo     eo    rd
        v[0]  = '{2'b01, 2'b01, 4'h3, 4'h3, A5, Z, 1'b1, 1'b0, A5, 2'b01, 1'b0, 1'b0, 1'b0, 4'h0, Z,  2'b00, 1'b0, Z};
        v[1]  = '{2'b00, 2'b01, 4'h3, 4'h3, A5, Z, 1'b1, 1'b0, A5, 2'b00, 1'b1, 1'b0, 1'b1, 4'h3, A5, 2'b00, 1'b0, Z};
        v[2]  = '{2'b00, 2'b01, 4'h3, 4'h3, A5, Z, 1'b1, 1'b0, A5, 2'b00, 1'b1, 1'b1, 1'b1, 4'h3, A5, 2'b00, 1'b0, Z};
        v[3]  = '{2'b10, 2'b00, 4'h3, 4'h3, A5, Z, 1'b1, 1'b0, A5, 2'b10, 1'b0, 1'b0, 1'b1, 4'h3, A5, 2'b01, 1'b0, Z};
        v[4]  = '{2'b00, 2'b00, 4'h3, 4'h3, A5, Z, 1'b1, 1'b0, A5, 2'b00, 1'b1, 1'b0, 1'b0, 4'h3, Z,  2'b00, 1'b0, Z};
        v[5]  = '{2'b00, 2'b00, 4'h3, 4'h3, A5, Z, 1'b1, 1'b0, A5, 2'b00, 1'b1, 1'b1, 1'b0, 4'h3, Z,  2'b00, 1'b0, Z};
        v[6]  = '{2'b00, 2'b00, 4'h3, 4'h3, A5, Z, 1'b1, 1'b0, A5, 2'b00, 1'b0, 1'b0, 1'b0, 4'h3, Z,  2'b10, 1'b0, A5};
        v[7]  = '{2'b00, 2'b00, 4'h3, 4'h3, A5, Z, 1'b1, 1'b0, A5, 2'b00, 1'b0, 1'b0, 1'b0, 4'h3, Z,  2'b00, 1'b0, A5};
        v[8]  = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b01, 1'b0, 1'b0, 1'b0, 4'h3, Z,  2'b00, 1'b0, A5};
        v[9]  = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b0, 1'b0, 4'h1, A5, 2'b00, 1'b0, A5};
        v[10] = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b1, 1'b0, 4'h1, A5, 2'b00, 1'b0, A5};
        v[11] = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b10, 1'b0, 1'b0, 1'b0, 4'h1, A5, 2'b01, 1'b0, P};
        v[12] = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b0, 1'b0, 4'h2, Z,  2'b00, 1'b0, P};
        v[13] = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b1, 1'b0, 4'h2, Z,  2'b00, 1'b0, P};
        v[14] = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b01, 1'b0, 1'b0, 1'b0, 4'h2, Z,  2'b10, 1'b0, P};
        v[15] = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b0, 1'b0, 4'h1, A5, 2'b00, 1'b0, P};
        v[16] = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b1, 1'b0, 4'h1, A5, 2'b00, 1'b0, P};
        v[17] = '{2'b11, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b10, 1'b0, 1'b0, 1'b0, 4'h1, A5, 2'b01, 1'b0, P};
        v[18] = '{2'b00, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b0, 1'b0, 4'h2, Z,  2'b00, 1'b0, P};
        v[19] = '{2'b00, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b1, 1'b0, 4'h2, Z,  2'b00, 1'b0, P};
        v[20] = '{2'b00, 2'b00, 4'h1, 4'h2, A5, Z, 1'b1, 1'b0, P,  2'b00, 1'b0, 1'b0, 1'b0, 4'h2, Z,  2'b10, 1'b0, P};
        v[21] = '{2'b01, 2'b01, 4'h5, 4'h2, W,  Z, 1'b0, 1'b0, P,  2'b01, 1'b0, 1'b0, 1'b0, 4'h2, Z,  2'b00, 1'b0, P};
        v[22] = '{2'b00, 2'b01, 4'h5, 4'h2, W,  Z, 1'b0, 1'b0, P,  2'b00, 1'b1, 1'b0, 1'b1, 4'h5, W,  2'b00, 1'b0, P};
        v[23] = '{2'b00, 2'b01, 4'h5, 4'h2, W,  Z, 1'b0, 1'b0, P,  2'b00, 1'b1, 1'b1, 1'b1, 4'h5, W,  2'b00, 1'b0, P};
        v[24] = '{2'b00, 2'b01, 4'h5, 4'h2, W,  Z, 1'b0, 1'b0, P,  2'b00, 1'b1, 1'b1, 1'b1, 4'h5, W,  2'b00, 1'b0, P};
        v[25] = '{2'b00, 2'b01, 4'h5, 4'h2, W,  Z, 1'b0, 1'b0, P,  2'b00, 1'b1, 1'b1, 1'b1, 4'h5, W,  2'b00, 1'b0, P};
        v[26] = '{2'b00, 2'b01, 4'h5, 4'h2, W,  Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b1, 1'b1, 4'h5, W,  2'b00, 1'b0, P};
        v[27] = '{2'b01, 2'b00, 4'h7, 4'h2, W,  Z, 1'b1, 1'b1, P,  2'b01, 1'b0, 1'b0, 1'b1, 4'h5, W,  2'b01, 1'b0, Z};
        v[28] = '{2'b00, 2'b00, 4'h7, 4'h2, W,  Z, 1'b1, 1'b1, P,  2'b00, 1'b1, 1'b0, 1'b0, 4'h7, W,  2'b00, 1'b0, Z};
        v[29] = '{2'b00, 2'b00, 4'h7, 4'h2, W,  Z, 1'b1, 1'b1, P,  2'b00, 1'b1, 1'b1, 1'b0, 4'h7, W,  2'b00, 1'b0, Z};
        v[30] = '{2'b10, 2'b00, 4'h7, 4'h8, W,  Z, 1'b1, 1'b0, P,  2'b10, 1'b0, 1'b0, 1'b0, 4'h7, W,  2'b01, 1'b1, P};
        v[31] = '{2'b00, 2'b00, 4'h7, 4'h8, W,  Z, 1'b1, 1'b1, P,  2'b00, 1'b1, 1'b0, 1'b0, 4'h8, Z,  2'b00, 1'b0, P};
        v[32] = '{2'b00, 2'b00, 4'h7, 4'h8, W,  Z, 1'b1, 1'b0, P,  2'b00, 1'b1, 1'b1, 1'b0, 4'h8, Z,  2'b00, 1'b0, P};
        v[33] = '{2'b00, 2'b00, 4'h7, 4'h8, W,  Z, 1'b1, 1'b0, P,  2'b00, 1'b0, 1'b0, 1'b0, 4'h8, Z,  2'b10, 1'b0, P};
        v[34] = '{2'b00, 2'b00, 4'h7, 4'h8, W,  Z, 1'b1, 1'b0, P,  2'b00, 1'b0, 1'b0, 1'b0, 4'h8, Z,  2'b00, 1'b0, P};

        // Reset state
        #12;
        chk_idle_outputs("reset");
        chk("reset req_ready", DW'(req_ready), Z);
        @(negedge PCLK);
        PRESETn = 1'b1;

        for (int i = 0; i < 35; i++) begin
            @(negedge PCLK);
            req_valid = v[i].rv;
            req_write = v[i].wr;
            req_addr  = {v[i].a1, v[i].a0};
            req_wdata = {v[i].d1, v[i].d0};
            PREADY    = v[i].rdy;
            PSLVERR   = v[i].err;
            PRDATA    = v[i].rdat;
            #1;
            chk($sformatf("v%0d req_ready", i), DW'(req_ready), DW'(v[i].rr));
            chk($sformatf("v%0d PSELx", i), DW'(PSELx), DW'(v[i].sel));
            chk($sformatf("v%0d PENABLE", i), DW'(PENABLE), DW'(v[i].en));
            chk($sformatf("v%0d PWRITE", i), DW'(PWRITE), DW'(v[i].pw));
            chk($sformatf("v%0d PADDR", i), DW'(PADDR), DW'(v[i].pa));
            chk($sformatf("v%0d PWDATA", i), PWDATA, v[i].pd);
            chk($sformatf("v%0d rsp_valid", i), DW'(rsp_valid), DW'(v[i].vo));
            chk($sformatf("v%0d rsp_err", i), DW'(rsp_err), DW'(v[i].eo));
            chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, v[i].rd);
        end

        // Reset in the middle of ACCESS: everything drops at once, no completion follows
        @(negedge PCLK);
        req_valid = 2'b01; req_write = 2'b00; req_addr = {4'h0, 4'h6}; PREADY = 1'b0; PSLVERR = 1'b0;
        #1 chk("midrst accept", DW'(req_ready), DW'(2'b01));
        @(negedge PCLK);
        req_valid = 2'b00;
        @(negedge PCLK);
        #1 chk("midrst in access", DW'({PSELx, PENABLE}), DW'(2'b11));
        PRESETn = 1'b0;
        #1 chk_idle_outputs("midrst");
        PREADY = 1'b1;
        repeat (2) @(posedge PCLK);
        #1 chk("midrst no rsp", DW'(rsp_valid), Z);
        @(negedge PCLK);
        PRESETn = 1'b1;
        req_valid = 2'b11;
        #1 chk("post-reset tie grants 0", DW'(req_ready), DW'(2'b01));
        req_valid = 2'b00;

        // A normal read so rsp_rdata holds non-zero data before the stalled transfer
        @(negedge PCLK);
        req_valid = 2'b10; req_addr = {4'h4, 4'h0}; PREADY = 1'b1; PRDATA = P;
        @(negedge PCLK);
        req_valid = 2'b00;
        repeat (2) @(negedge PCLK);
        #1 chk("read before stall rsp_valid", DW'(rsp_valid), DW'(2'b10));
        chk("read before stall rdata", rsp_rdata, P);

        // Stalled slave: PREADY stuck low during ACCESS
        @(negedge PCLK);
        req_valid = 2'b01; req_addr = {4'h0, 4'h9}; PREADY = 1'b0;
        @(negedge PCLK);
        req_valid = 2'b00;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge PCLK);
            #1;
            if (!PENABLE) break;
            n++;
        end
`ifdef APB_TIMEOUT_EN
        chk("timeout ACCESS length", DW'(n), DW'(16));
        chk("timeout rsp_valid", DW'(rsp_valid), DW'(2'b01));
        chk("timeout rsp_err", DW'(rsp_err), DW'(1'b1));
        chk("timeout rsp_rdata", rsp_rdata, Z);
        chk("timeout PSELx", DW'(PSELx), Z);
`else
        chk("stall ACCESS held", DW'(n), DW'(40));
        chk("stall no rsp", DW'(rsp_valid), Z);
        PREADY = 1'b1;
        @(negedge PCLK);
        #1 chk("stall release rsp_valid", DW'(rsp_valid), DW'(2'b01));
        chk("stall release rsp_err", DW'(rsp_err), Z);
        chk("stall release rdata", rsp_rdata, P);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Two-requester APB master that shares one APB slave (4-bit address, 128-bit data) between two on-chip clients.
- Arbitrates round-robin, sequences the APB SETUP/ACCESS phases, absorbs slave wait states and returns read data and error status to the granted requester.
- Sits between the requester logic and the slave's PSELx/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR pins.

Parameters:
- ADDR_WIDTH, 4, APB address width (PADDR, req_addr lanes).
- DATA_WIDTH, 128, APB data width (PWDATA, PRDATA, req_wdata lanes, rsp_rdata).
- TIMEOUT_CYCLES, 16, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock; all flops rise on PCLK.
- PRESETn  in  1  asynchronous active-low reset.
- req_valid  in  2  bit i: requester i has a transfer pending; held with fields until accepted.
- req_write  in  2  bit i: 1 = write, 0 = read.
- req_addr  in  2*ADDR_WIDTH  lane i = [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  lane i = [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  2  one-hot accept strobe (combinational, IDLE only).
- rsp_valid  out  2  one-hot, 1-cycle completion pulse to the granted requester.
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid; 0 for writes.
- rsp_err  out  1  error flag, valid with rsp_valid.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_WIDTH  APB address.
- PWDATA  out  DATA_WIDTH  APB write data.
- PRDATA  in  DATA_WIDTH  slave read data.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (async, PRESETn=0): all outputs 0; FSM returns to IDLE; round-robin pointer last=1 so requester 0 wins the first tie. Reset mid-transfer drops PSELx/PENABLE immediately and issues no rsp_valid.
- FSM states: IDLE, SETUP, ACCESS. All APB outputs, rsp_* and last are registered.
- IDLE: grant g = the only valid requester, or on a tie the requester != last. req_ready[g]=1 combinationally that cycle. On the edge:
  - latch req_write/req_addr/req_wdata of g into PWRITE/PADDR/PWDATA;
  - set PSELx=1, PENABLE=0; last<=g; go to SETUP.
  - No valid: stay in IDLE; req_ready=0.
- SETUP: exactly 1 cycle. PENABLE<=1; go to ACCESS.
- ACCESS: PSELx=1, PENABLE=1; PADDR/PWDATA/PWRITE stable.
  - PREADY=0: stay.
  - PREADY=1: on that edge PSELx<=0, PENABLE<=0, rsp_valid[g]<=1, rsp_err<=PSLVERR, rsp_rdata<=PWRITE?0:PRDATA; go to IDLE.
  - PSLVERR is ignored outside ACCESS&PREADY.
- rsp_valid and rsp_err clear after 1 cycle. rsp_rdata holds until the next completion. PADDR/PWDATA/PWRITE hold their last values while idle.
- Latency, with accept at cycle T and zero wait states:
  - SETUP at T+1, ACCESS at T+2, rsp_valid at T+3.
  - The next accept can occur at T+3 (IDLE coincides with the rsp cycle).
  - Minimum 3 cycles per transfer. Each wait state adds 1 cycle.
- req_ready is never asserted outside IDLE; only one transfer is outstanding at a time.
- Under continuous contention, grants strictly alternate 0,1,0,1…; a lone requester may be granted back-to-back.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter clears on ACCESS entry and increments each ACCESS cycle with PREADY=0.
  - If PREADY=0 in the cycle where the count equals TIMEOUT_CYCLES-1, the transfer terminates on that edge: PSELx/PENABLE<=0, rsp_valid[g]<=1, rsp_err<=1, rsp_rdata<=0; go to IDLE.
  - ACCESS therefore lasts at most TIMEOUT_CYCLES cycles. PREADY=1 in the final cycle completes the transfer normally.
- APB_TIMEOUT_EN not defined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is unused.

Test Plan:
- Reset, req0 write addr 0x3 data 0xA5…A5, PREADY=1 → accept at T; PSELx=1 at T+1; PENABLE=1 at T+2; rsp_valid=2'b01 at T+3 with rsp_err=0, rsp_rdata=0.
- req1 read addr 0x3 after the above → slave returns 0xA5…A5; rsp_valid=2'b10; rsp_rdata=0xA5…A5.
- Both req_valid held high for 4 transfers from reset → req_ready sequence 01,10,01,10; each transfer 3 cycles; no overlap.
- PREADY low for 3 ACCESS cycles → PSELx/PENABLE/PADDR/PWDATA stable throughout; rsp_valid exactly 1 cycle after PREADY rises; 6 cycles total.
- PSLVERR=1 with PREADY on a req0 read → rsp_valid=2'b01, rsp_err=1; the next req1 transfer returns rsp_err=0.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY stuck 0 → PENABLE high for exactly 16 cycles, then rsp_err=1, rsp_rdata=0. Separately, PRESETn=0 mid-ACCESS → PSELx=PENABLE=0 immediately; no rsp_valid.
